// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN input-stream blocks.
package cnn_pkg;

  localparam int unsigned IMG_W  = 30;
  localparam int unsigned IMG_H  = 30;
  localparam int unsigned PIX_N  = IMG_W * IMG_H;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; push+pop in the same cycle is legal when full or empty.
module stream_fifo2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop on empty is dropped; a push on full only lands if a pop frees the slot.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/data_rom_stream_ctrl.sv
// Streams the test-image ROM one pixel per cycle in raster order with
// valid/ready handshake, row/col tags and frame markers.
module data_rom_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H  = cnn_pkg::IMG_H,
  parameter int unsigned DATA_W = cnn_pkg::DATA_W,
  parameter int unsigned ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [4:0]        m_row,
  output logic [4:0]        m_col,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state;
  logic [CNT_W-1:0]    issue_cnt;
  logic [ADDR_W-1:0]   last_addr;
  logic                inflight;
  logic [TAG_W-1:0]    row_q;
  logic [TAG_W-1:0]    col_q;
  logic [1:0]          buf_count;
  logic [DATA_W-1:0]   buf_head;
  logic [2:0]          occ;
  logic                pop;
  logic                col_last;
  logic                last_pix;

  stream_fifo2 #(.W(DATA_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (rom_data),
    .dout  (buf_head),
    .count (buf_count)
  );

  assign m_valid  = (buf_count != 2'd0);
  assign pop      = m_valid & m_ready;
  assign col_last = (col_q == TAG_W'(IMG_W - 1));
  assign last_pix = col_last && (row_q == TAG_W'(IMG_H - 1));

  // Credit: in-flight read plus buffered words after this cycle's pop must leave a free slot.
  assign occ      = 3'(inflight) + 3'(buf_count) - 3'(pop);
  assign rom_en   = (state == RUN) && (occ < 3'd2) && (issue_cnt < CNT_W'(NPIX));
  assign rom_addr = rom_en ? issue_cnt[ADDR_W-1:0] : last_addr;

  assign m_data = m_valid ? buf_head : '0;
  assign m_row  = m_valid ? row_q : '0;
  assign m_col  = m_valid ? col_q : '0;
  assign m_sof  = m_valid && (row_q == '0) && (col_q == '0);
  assign m_eol  = m_valid && col_last;
  assign m_eof  = m_valid && last_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= rom_en;

      if (rom_en) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
        last_addr <= issue_cnt[ADDR_W-1:0];
      end

      if (pop) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + TAG_W'(1);
        end else begin
          col_q <= col_q + TAG_W'(1);
        end
      end

      case (state)
        IDLE: begin
          issue_cnt <= '0;
          row_q     <= '0;
          col_q     <= '0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (rom_en && (issue_cnt == CNT_W'(NPIX - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_pix) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_rom_stream_ctrl.sv
// Randomised directed bench for data_rom_stream_ctrl: a 30x30 instance and a 4x3 instance
// are checked against a pixel-index reference model with a behavioural ROM.
module tb_data_rom_stream_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst;
  logic start_b;
  logic start_s;
  logic m_ready;

  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:1023];

  logic          b_busy, b_done, b_rom_en, b_m_valid, b_sof, b_eol, b_eof;
  logic [AW-1:0] b_rom_addr;
  logic [DW-1:0] b_rom_data, b_m_data;
  logic [4:0]    b_m_row, b_m_col;

  logic          s_busy, s_done, s_rom_en, s_m_valid, s_sof, s_eol, s_eof;
  logic [AW-1:0] s_rom_addr;
  logic [DW-1:0] s_rom_data, s_m_data;
  logic [4:0]    s_m_row, s_m_col;

  data_rom_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(m_ready),
    .m_row(b_m_row), .m_col(b_m_col), .m_sof(b_sof), .m_eol(b_eol), .m_eof(b_eof)
  );

  data_rom_stream_ctrl #(.IMG_W(4), .IMG_H(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(s_busy), .done(s_done),
    .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .m_data(s_m_data), .m_valid(s_m_valid), .m_ready(m_ready),
    .m_row(s_m_row), .m_col(s_m_col), .m_sof(s_sof), .m_eol(s_eol), .m_eof(s_eof)
  );

  // Behavioural ROM: one-cycle read latency per instance.
  always @(posedge clk) begin
    if (b_rom_en) b_rom_data <= rom[b_rom_addr];
    if (s_rom_en) s_rom_data <= rom[s_rom_addr];
  end

  bit sel = 1'b0;
  int w = 30;
  int h = 30;

  logic          o_busy, o_done, o_rom_en, o_m_valid, o_sof, o_eol, o_eof;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] o_m_data;
  logic [4:0]    o_m_row, o_m_col;

  assign o_busy     = sel ? s_busy     : b_busy;
  assign o_done     = sel ? s_done     : b_done;
  assign o_rom_en   = sel ? s_rom_en   : b_rom_en;
  assign o_rom_addr = sel ? s_rom_addr : b_rom_addr;
  assign o_m_data   = sel ? s_m_data   : b_m_data;
  assign o_m_valid  = sel ? s_m_valid  : b_m_valid;
  assign o_m_row    = sel ? s_m_row    : b_m_row;
  assign o_m_col    = sel ? s_m_col    : b_m_col;
  assign o_sof      = sel ? s_sof      : b_sof;
  assign o_eol      = sel ? s_eol      : b_eol;
  assign o_eof      = sel ? s_eof      : b_eof;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tags();
    return 32'({o_m_row, o_m_col, o_sof, o_eol, o_eof});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rom_en"}, o_rom_en, 0);
    chk({tag, "_rom_addr"}, o_rom_addr, 0);
    chk({tag, "_m_valid"}, o_m_valid, 0);
    chk({tag, "_m_data"}, o_m_data, 0);
    chk({tag, "_tags"}, tags(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(1));
      #1;
      chk("idle_done", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_rom_en", o_rom_en, 0);
      chk("idle_valid", o_m_valid, 0);
    end
  endtask

  // Runs one frame starting in the current cycle (cycle 0). Pixel k must carry rom[k].
  task automatic do_frame(input int pct, input int stall_until, input int poke_pix,
                          input int rst_pix, output int last_hs);
    int np, issued, nxt, occ, rel, pend_en;
    bit prev_en, prev2_en, prev_pop, prev_stall, poked, pop;
    logic [31:0] p_data, p_tags;
    np = w * h; issued = 0; nxt = 0; occ = 0; rel = 0;
    prev_en = 0; prev2_en = 0; prev_pop = 0; prev_stall = 0; poked = 0;
    p_data = 0; p_tags = 0; last_hs = -1;
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    m_ready = (stall_until > 0) ? 1'b0 : 1'b1;
    #1;
    chk("c0_busy", o_busy, 0);
    chk("c0_rom_en", o_rom_en, 0);
    while (1) begin
      @(posedge clk); #1;
      rel++;
      start_b = 1'b0; start_s = 1'b0;
      if (!poked && poke_pix >= 0 && nxt >= poke_pix) begin
        if (sel) start_s = 1'b1; else start_b = 1'b1;
        poked = 1'b1;
      end
      m_ready = (rel < stall_until) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      // Buffer holds what was read two cycles ago and not yet taken.
      occ = occ + int'(prev2_en) - int'(prev_pop);
      pop = o_m_valid & m_ready;
      chk("busy", o_busy, (last_hs < 0));
      chk("done", o_done, (last_hs >= 0 && rel == last_hs + 1));
      chk("m_valid", o_m_valid, (occ != 0));
      if (rel == 1) chk("first_rd", o_rom_en, 1);
      if (rel == 3) chk("first_valid", o_m_valid, 1);
      if (o_rom_en) begin
        pend_en = int'(prev_en) + occ - int'(pop);
        chk("addr", o_rom_addr, issued);
        chk("credit", (pend_en < 2), 1);
        chk("issue_limit", (issued < np), 1);
        issued++;
      end
      if (stall_until > 0 && rel == stall_until - 1) chk("stall_reads", issued, 2);
      if (o_m_valid) begin
        if (prev_stall) begin
          chk("stable_data", o_m_data, p_data);
          chk("stable_tags", tags(), p_tags);
        end
        chk("data", o_m_data, rom[nxt]);
        chk("row", o_m_row, nxt / w);
        chk("col", o_m_col, nxt % w);
        chk("sof", o_sof, (nxt == 0));
        chk("eol", o_eol, ((nxt % w) == w - 1));
        chk("eof", o_eof, (nxt == np - 1));
      end else begin
        chk("gated_data", o_m_data, 0);
        chk("gated_tags", tags(), 0);
      end
      p_data = 32'(o_m_data); p_tags = tags();
      prev_stall = o_m_valid & !m_ready;
      prev2_en = prev_en; prev_en = o_rom_en; prev_pop = pop;
      if (pop) begin
        nxt++;
        if (nxt == np) last_hs = rel;
      end
      if (rst_pix >= 0 && nxt >= rst_pix) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_ready = 1'b1;
        #1;
        chk_all_zero("after_rst");
        break;
      end
      if (last_hs >= 0 && rel == last_hs + 1) break;
      if (rel > 8000) begin
        chk("timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int lh;
    rst = 1'b1; start_b = 1'b0; start_s = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = DW'(i);
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    sel = 1'b1;
    #1;
    chk_all_zero("reset_s");
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-rate frame with identity ROM: last handshake in cycle 902.
    do_frame(100, 0, -1, -1, lh);
    chk("fullrate_last_hs", lh, 902);
    idle(3);

    for (int i = 0; i < 1024; i++) rom[i] = DW'($urandom);

    // Random back-pressure.
    do_frame(50, 0, -1, -1, lh);
    idle(2);

    // Stalled until cycle 20.
    do_frame(100, 20, -1, -1, lh);
    idle(2);

    // Ignored start mid-frame, then a start in the done cycle.
    do_frame(60, 0, 400, -1, lh);
    do_frame(100, 0, -1, -1, lh);
    chk("chained_last_hs", lh, 902);
    idle(3);

    // Reset mid-frame, then a clean full frame.
    do_frame(70, 0, -1, 500, lh);
    idle(3);
    do_frame(100, 0, -1, -1, lh);
    chk("post_rst_last_hs", lh, 902);
    idle(2);

    // 4x3 instance.
    sel = 1'b1; w = 4; h = 3;
    #1;
    do_frame(100, 0, -1, -1, lh);
    chk("small_last_hs", lh, 14);
    idle(2);
    do_frame(50, 0, -1, -1, lh);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
